// File: rtl/modulator_pkg.sv
// Shared constants for the modulator datapath: comparator relation codes and default operand width.
// Pure declarations; no logic, no latency, no flow control.
// Imported by comparator and comparator_core.
package modulator_pkg;

    localparam int MOD_WIDTH = 8;

    localparam int CMP_LT = 0;
    localparam int CMP_LE = 1;
    localparam int CMP_GT = 2;
    localparam int CMP_GE = 3;
    localparam int CMP_EQ = 4;
    localparam int CMP_NE = 5;

endpackage

// File: rtl/comparator_core.sv
// Combinational magnitude compare producing less-than and equal flags, unsigned or two's complement.
// Latency: none (pure combinational).
// Backpressure: none; evaluates continuously.
module comparator_core
    import modulator_pkg::*;
#(
    parameter int WIDTH      = MOD_WIDTH,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq
);

    // Flipping both sign bits maps two's complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    localparam logic [WIDTH-1:0] SIGN_FLIP =
        SIGNED_CMP ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;

    assign a_k = a ^ SIGN_FLIP;
    assign b_k = b ^ SIGN_FLIP;

    assign lt = (a_k < b_k);
    assign eq = (a == b);

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator: out = relation(in1, in2), relation fixed by CMP_MODE.
// Latency: 1 clock from sampling edge to out; one compare per clock.
// Backpressure: none; no handshake or enable, synchronous active-high reset clears out.
module comparator
    import modulator_pkg::*;
#(
    parameter int WIDTH      = MOD_WIDTH,
    parameter int CMP_MODE   = CMP_LT,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out
);

    logic lt;
    logic eq;
    logic rel;

    comparator_core #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP != 0)
    ) u_core (
        .a  (in1),
        .b  (in2),
        .lt (lt),
        .eq (eq)
    );

    // CMP_MODE is an elaboration constant, so this collapses to a single gate.
    always_comb begin
        rel = lt;
        case (CMP_MODE)
            CMP_LE:  rel = lt | eq;
            CMP_GT:  rel = ~(lt | eq);
            CMP_GE:  rel = ~lt;
            CMP_EQ:  rel = eq;
            CMP_NE:  rel = ~eq;
            default: rel = lt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= rel;
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Directed bench for comparator: one instance per relation plus signed and out-of-range mode,
// all sharing the same clock, reset and operands.
module tb_comparator;

    logic       clk;
    logic       rst;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       o_lt, o_le, o_gt, o_ge, o_eq, o_ne, o_slt, o_bad;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    comparator #(.WIDTH(8), .CMP_MODE(0), .SIGNED_CMP(0)) u_lt (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_lt));
    comparator #(.WIDTH(8), .CMP_MODE(1), .SIGNED_CMP(0)) u_le (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_le));
    comparator #(.WIDTH(8), .CMP_MODE(2), .SIGNED_CMP(0)) u_gt (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_gt));
    comparator #(.WIDTH(8), .CMP_MODE(3), .SIGNED_CMP(0)) u_ge (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_ge));
    comparator #(.WIDTH(8), .CMP_MODE(4), .SIGNED_CMP(0)) u_eq (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_eq));
    comparator #(.WIDTH(8), .CMP_MODE(5), .SIGNED_CMP(0)) u_ne (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_ne));
    comparator #(.WIDTH(8), .CMP_MODE(0), .SIGNED_CMP(1)) u_slt (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_slt));
    comparator #(.WIDTH(8), .CMP_MODE(7), .SIGNED_CMP(0)) u_bad (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(o_bad));

    // Apply operands away from the edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        in1 = 8'h00;
        in2 = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_lt !== 1'b0) begin
            errors++;
            $display("FAIL reset_lt got %b exp 0", o_lt);
        end
        checks++;
        if (o_ne !== 1'b0) begin
            errors++;
            $display("FAIL reset_ne got %b exp 0", o_ne);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (o_lt !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_lt got %b exp 1", o_lt);
        end
    endtask

    task automatic test_lt_unsigned;
        logic [7:0] ta [6] = '{8'h66, 8'h54, 8'h2C, 8'h94, 8'h00, 8'hFF};
        logic [7:0] tb [6] = '{8'h67, 8'h61, 8'h2C, 8'h6A, 8'hFF, 8'hFF};
        logic       te [6] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(ta[i], tb[i]);
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (o_lt !== te[i]) begin
                errors++;
                $display("FAIL lt_unsigned[%0d] %h<%h got %b exp %b", i, ta[i], tb[i], o_lt, te[i]);
            end
            checks++;
            if (o_bad !== te[i]) begin
                errors++;
                $display("FAIL bad_mode_as_lt[%0d] got %b exp %b", i, o_bad, te[i]);
            end
        end
    endtask

    task automatic test_latency;
        apply(8'h2C, 8'h2C);
        checks++;
        if (o_lt !== 1'b0) begin
            errors++;
            $display("FAIL latency_pre got %b exp 0", o_lt);
        end
        #3;
        in1 = 8'h2B;
        #1;
        checks++;
        if (o_lt !== 1'b0) begin
            errors++;
            $display("FAIL latency_midcycle got %b exp 0", o_lt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_lt !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge got %b exp 1", o_lt);
        end
    endtask

    task automatic test_mode_sweep;
        // Columns: le, gt, ge, eq, ne
        logic [7:0] ta [3] = '{8'h2C, 8'h94, 8'h00};
        logic [7:0] tb [3] = '{8'h2C, 8'h6A, 8'hFF};
        logic [4:0] te [3] = '{5'b10110, 5'b01101, 5'b10001};
        logic [4:0] got;
        for (int i = 0; i < 3; i++) begin
            apply(ta[i], tb[i]);
            got = {o_le, o_gt, o_ge, o_eq, o_ne};
            checks++;
            if (got !== te[i]) begin
                errors++;
                $display("FAIL mode_sweep[%0d] %h/%h le,gt,ge,eq,ne got %b exp %b", i, ta[i], tb[i], got, te[i]);
            end
        end
    endtask

    task automatic test_signed;
        logic [7:0] ta [6] = '{8'h94, 8'h80, 8'hFF, 8'h00, 8'h80, 8'h7F};
        logic [7:0] tb [6] = '{8'h6A, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h80};
        logic       te [6] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(ta[i], tb[i]);
            checks++;
            if (o_slt !== te[i]) begin
                errors++;
                $display("FAIL signed_lt[%0d] %h<%h got %b exp %b", i, ta[i], tb[i], o_slt, te[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        apply(8'h00, 8'hFF);
        checks++;
        if (o_lt !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_before got %b exp 1", o_lt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o_lt !== 1'b0 || o_ne !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_asserted lt,ne got %b%b exp 00", o_lt, o_ne);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (o_lt !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_resume got %b exp 1", o_lt);
        end
    endtask

    initial begin
        rst = 1'b1;
        in1 = 8'h00;
        in2 = 8'h00;
        test_reset();
        test_lt_unsigned();
        test_latency();
        test_mode_sweep();
        test_signed();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
